// File: rtl/riscv_test_monitor.sv
// Run-completion monitor: watches fetch PCs for qualified self-loops on pass/fail addresses, with timeout.
// Optional trace buffer of recent fetch PCs enabled by defining RISCV_TEST_MONITOR_TRACE_EN.
module riscv_test_monitor #(
    parameter int NUM_WATCH    = 2,
    parameter int ADDR_W       = 32,
    parameter int CNT_W        = 32,
    parameter int TIMEOUT      = 100000,
    parameter int HOLD_FETCHES = 4,
    parameter int TRACE_DEPTH  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          enable_i,
    input  logic                          clear_i,
    input  logic [NUM_WATCH*ADDR_W-1:0]   watch_addr_i,
    input  logic [NUM_WATCH-1:0]          watch_pass_i,
    input  logic                          fetch_valid_i,
    input  logic [ADDR_W-1:0]             fetch_pc_i,
    output logic                          done_o,
    output logic                          pass_o,
    output logic                          fail_o,
    output logic                          timeout_o,
    output logic [2:0]                    hit_idx_o,
    output logic [ADDR_W-1:0]             stop_pc_o,
    output logic [CNT_W-1:0]              cycles_o,
    output logic [CNT_W-1:0]              fetches_o,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx_i,
    output logic [ADDR_W-1:0]             trace_pc_o
);

    localparam int HW = $clog2(HOLD_FETCHES + 1);
    localparam int TW = $clog2(TRACE_DEPTH);

    // IDLE: waiting for enable | RUN: counting and tracking | DONE: verdict held until clear
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic [CNT_W-1:0]  fetches_q, fetches_d;
    logic [2:0]        match_ch_q, match_ch_d;
    logic [HW-1:0]     match_cnt_q, match_cnt_d;
    logic [ADDR_W-1:0] last_pc_q;
    logic              done_q, pass_q, fail_q, timeout_q;
    logic [2:0]        hit_idx_q;
    logic [ADDR_W-1:0] stop_pc_q;

    logic              hit_any;
    logic [2:0]        hit_ch;
    logic              hit_pass;
    logic              counting;
    logic              fetch_cnt;
    logic              qualify;
    logic              timeout_hit;

    always_comb begin
        hit_any  = 1'b0;
        hit_ch   = '0;
        hit_pass = 1'b0;
        // Descending scan so the lowest matching channel is the one left standing.
        for (int j = NUM_WATCH - 1; j >= 0; j--) begin
            if (fetch_pc_i == watch_addr_i[j*ADDR_W +: ADDR_W]) begin
                hit_any  = 1'b1;
                hit_ch   = 3'(j);
                hit_pass = watch_pass_i[j];
            end
        end

        match_ch_d  = match_ch_q;
        match_cnt_d = match_cnt_q;
        if (!hit_any) begin
            match_cnt_d = '0;
        end else if ((hit_ch == match_ch_q) && (match_cnt_q != '0)) begin
            match_cnt_d = match_cnt_q + 1'b1;
        end else begin
            match_ch_d  = hit_ch;
            match_cnt_d = HW'(1);
        end

        counting    = (state_q == RUN) && enable_i;
        fetch_cnt   = counting && fetch_valid_i;
        qualify     = fetch_cnt && hit_any && (match_cnt_d == HW'(HOLD_FETCHES));
        cycles_d    = (&cycles_q)  ? cycles_q  : cycles_q + 1'b1;
        fetches_d   = (&fetches_q) ? fetches_q : fetches_q + 1'b1;
        timeout_hit = (TIMEOUT != 0) && (cycles_d == CNT_W'(TIMEOUT));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cycles_q    <= '0;
            fetches_q   <= '0;
            match_ch_q  <= '0;
            match_cnt_q <= '0;
            last_pc_q   <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            hit_idx_q   <= '0;
            stop_pc_q   <= '0;
        end else if (clear_i) begin
            state_q     <= IDLE;
            cycles_q    <= '0;
            fetches_q   <= '0;
            match_ch_q  <= '0;
            match_cnt_q <= '0;
            last_pc_q   <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            hit_idx_q   <= '0;
            stop_pc_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_i) state_q <= RUN;
                end
                RUN: begin
                    if (enable_i) begin
                        cycles_q <= cycles_d;
                        if (fetch_valid_i) begin
                            fetches_q   <= fetches_d;
                            last_pc_q   <= fetch_pc_i;
                            match_ch_q  <= match_ch_d;
                            match_cnt_q <= match_cnt_d;
                        end
                        // A qualified hit on the timeout edge still counts as a real verdict.
                        if (qualify) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            pass_q    <= hit_pass;
                            fail_q    <= !hit_pass;
                            hit_idx_q <= hit_ch;
                            stop_pc_q <= fetch_pc_i;
                        end else if (timeout_hit) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            timeout_q <= 1'b1;
                            stop_pc_q <= fetch_valid_i ? fetch_pc_i : last_pc_q;
                        end
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign fail_o    = fail_q;
    assign timeout_o = timeout_q;
    assign hit_idx_o = hit_idx_q;
    assign stop_pc_o = stop_pc_q;
    assign cycles_o  = cycles_q;
    assign fetches_o = fetches_q;

`ifdef RISCV_TEST_MONITOR_TRACE_EN
    logic [ADDR_W-1:0] trace_q [TRACE_DEPTH];
    logic [TW-1:0]     wr_ptr_q;
    logic [TW:0]       fill_q;
    logic [TW-1:0]     rd_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < TRACE_DEPTH; i++) trace_q[i] <= '0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else if (fetch_cnt) begin
            trace_q[wr_ptr_q] <= fetch_pc_i;
            wr_ptr_q          <= wr_ptr_q + 1'b1;
            if (fill_q != (TW+1)'(TRACE_DEPTH)) fill_q <= fill_q + 1'b1;
        end
    end

    // fill_q masks stale entries left over from before a clear.
    assign rd_ptr     = wr_ptr_q - TW'(1) - trace_idx_i;
    assign trace_pc_o = ({1'b0, trace_idx_i} < fill_q) ? trace_q[rd_ptr] : '0;
`else
    logic unused_trace;
    assign unused_trace = ^trace_idx_i;
    assign trace_pc_o   = '0;
`endif

endmodule

// File: doc/riscv_test_monitor.md
Name: riscv_test_monitor

Overview:
- Synthesizable run-completion monitor for core bring-up and regression builds; replaces ad-hoc bench-level PC comparison with an RTL block usable in simulation, FPGA and emulation.
- Snoops the instruction fetch stream and matches the PC against NUM_WATCH runtime-programmable watch addresses, each tagged pass or fail.
- Declares a verdict only after a qualified self-loop: HOLD_FETCHES consecutive fetches at the same watch address.
- Provides a cycle timeout, cycle and fetch counters, and the stop PC.

Parameters:
NUM_WATCH, 2, number of watch channels (1..8)
ADDR_W, 32, PC width
CNT_W, 32, width of cycle and fetch counters
TIMEOUT, 100000, RUN cycles before timeout verdict; 0 disables timeout
HOLD_FETCHES, 4, consecutive matching fetches required to qualify a hit (>=1)
TRACE_DEPTH, 8, trace buffer entries, power of 2 (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  run enable; low pauses the monitor
clear_i  in  1  synchronous clear to IDLE
watch_addr_i  in  NUM_WATCH*ADDR_W  watch addresses, channel j at [j*ADDR_W +: ADDR_W]
watch_pass_i  in  NUM_WATCH  per channel: 1 = pass, 0 = fail
fetch_valid_i  in  1  fetch accepted this cycle (mem_i_rd_o & mem_i_accept_i)
fetch_pc_i  in  ADDR_W  PC of the accepted fetch
done_o  out  1  verdict reached (sticky)
pass_o  out  1  qualified hit on a pass channel
fail_o  out  1  qualified hit on a fail channel
timeout_o  out  1  timeout verdict
hit_idx_o  out  3  channel index of the qualified hit
stop_pc_o  out  ADDR_W  PC of the qualifying fetch, or last fetch PC on timeout
cycles_o  out  CNT_W  RUN cycles counted
fetches_o  out  CNT_W  fetches counted in RUN
trace_idx_i  in  log2(TRACE_DEPTH)  trace read index; 0 = newest
trace_pc_o  out  ADDR_W  trace read data

Behaviour:
- Reset: all outputs and internal registers are 0; state is IDLE.
- State IDLE:
  - No counting.
  - enable_i=1 -> RUN on the next edge.
- State RUN, any cycle with enable_i=1:
  - cycles increments.
  - fetch_valid_i increments fetches.
  - Both counters saturate at all-ones.
- RUN with enable_i=0: counters, match tracker and trace freeze; state stays RUN.
- Channel match:
  - Channel matches when fetch_pc_i == watch_addr_i[j].
  - Lowest index wins on multiple matches.
  - Watch inputs are sampled every cycle, not latched.
- Match tracker (match_ch, match_cnt), updated on fetch_valid_i in RUN:
  - Same channel as match_ch with match_cnt>0: match_cnt+1.
  - Different channel: match_ch=j, match_cnt=1.
  - No match: match_cnt=0.
  - Cycles without fetch_valid_i leave the tracker unchanged.
- Qualification: when the updated match_cnt reaches HOLD_FETCHES, go to DONE on that edge.
  - pass_o or fail_o is set per watch_pass_i[j].
  - hit_idx_o=j, stop_pc_o=fetch_pc_i.
- Timeout: TIMEOUT!=0 and the cycle increment makes cycles equal TIMEOUT -> DONE.
  - timeout_o=1.
  - stop_pc_o = last fetch PC seen in RUN (0 if none).
- Same-edge qualification and timeout: qualification wins; timeout_o stays 0.
- DONE:
  - Exactly one of pass_o/fail_o/timeout_o is 1; done_o=1.
  - All outputs hold; fetches and enable_i are ignored.
- clear_i (any state, priority over everything):
  - Next edge goes to IDLE.
  - Clears counters, tracker, verdict outputs and trace write pointer.
- Outputs are registered. The verdict is visible 1 cycle after the qualifying fetch edge.
- Reset asserted mid-RUN: immediate return to reset values, independent of the clock.

Optional Feature:
- Macro: RISCV_TEST_MONITOR_TRACE_EN.
- Defined:
  - Circular buffer of TRACE_DEPTH PCs is written on every counted fetch; the write pointer wraps.
  - trace_pc_o = entry written trace_idx_i fetches before the newest (combinational read).
  - Entries not yet written read 0.
  - Writes stop in DONE, so the buffer holds the last fetches before the verdict.
- Not defined: no buffer storage; trace_pc_o is tied to 0.

Test Plan:
- Pass loop: watch0=0x80000140 pass, watch1=0x80000144 fail, HOLD=4; fetch sequence 0x80000000..0x8000013C, then 0x80000140 x4 -> pass_o=1, hit_idx_o=0, stop_pc_o=0x80000140, done_o 1 cycle after the 4th fetch.
- Broken loop: fetch 0x80000144 x3, then 0x80000148, then 0x80000144 x4 -> no verdict until the 4th fetch of the second run; then fail_o=1, hit_idx_o=1.
- Timeout: TIMEOUT=50, no watch hits -> timeout_o=1 with cycles_o=50; stop_pc_o = last fetch PC.
- Simultaneous: the 4th qualifying fetch lands on the cycle where cycles reaches TIMEOUT -> pass_o=1, timeout_o=0.
- Pause/clear/reset: enable_i low for 10 cycles mid-RUN -> cycles_o frozen. clear_i in DONE -> all outputs 0 next cycle, IDLE. rst_ni low mid-RUN -> outputs 0 without a clock edge.
- Trace (macro defined, DEPTH=8): 12 fetches with PCs 0x100+4k, k=0..11 -> trace_idx 0 reads 0x12C, idx 7 reads 0x110; macro undefined -> trace_pc_o=0.
